// File: rtl/divided_clock_monitor.sv
// divided_clock_monitor
// Fast-domain monitor for the divide-by-128 sample clock. Synchronizes the
// divided clock into clk, emits one-cycle rise/fall strobes, measures every
// half period in clk cycles and reports lock / loss against EXPECTED_HALF.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   clk_div_in   in   divided clock under observation (async to clk)
//   rise_pulse   out  one-cycle strobe per detected rising edge
//   fall_pulse   out  one-cycle strobe per detected falling edge
//   half_period  out  last measured half period (clk cycles)
//   half_valid   out  one-cycle strobe when half_period updates
//   locked       out  divided clock within tolerance
//   lost         out  no edge seen for TIMEOUT cycles
module divided_clock_monitor #(
  parameter int unsigned EXPECTED_HALF = 64,
  parameter int unsigned TOL           = 2,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned TIMEOUT       = 192,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             half_valid,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned EXT_W   = CNT_W + 1;
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [CNT_W-1:0]   r_cnt;
  logic [MATCH_W-1:0] r_match;
  logic               r_rise_pulse;
  logic               r_fall_pulse;
  logic [CNT_W-1:0]   r_half_period;
  logic               r_half_valid;
  logic               r_locked;
  logic               r_lost;

  logic               w_rise;
  logic               w_fall;
  logic               w_edge;
  logic               w_seen;
  logic               w_timeout;
  logic [EXT_W-1:0]   w_cnt_ext;
  logic [EXT_W-1:0]   w_diff;
  logic               w_in_tol;

  // Edge detect on the synchronized level against its one-cycle history
  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_edge = r_s2 ^ r_s3;

  // A reference edge exists exactly when the FSM has left IDLE
  assign w_seen = (r_state != ST_IDLE);

  // An edge in the timeout cycle wins over the timeout
  assign w_timeout = ~w_edge && (r_cnt == CNT_W'(TIMEOUT));

  // |cnt - EXPECTED_HALF| at one extra bit, ordered subtraction so it never wraps
  assign w_cnt_ext = EXT_W'(r_cnt);
  always_comb begin
    w_diff = '0;
    if (w_cnt_ext >= EXT_W'(EXPECTED_HALF)) begin
      w_diff = w_cnt_ext - EXT_W'(EXPECTED_HALF);
    end else begin
      w_diff = EXT_W'(EXPECTED_HALF) - w_cnt_ext;
    end
  end
  assign w_in_tol = (w_diff <= EXT_W'(TOL));

  // Synchronizer, strobes, interval counter and lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_cnt         <= '0;
      r_match       <= '0;
      r_rise_pulse  <= 1'b0;
      r_fall_pulse  <= 1'b0;
      r_half_period <= '0;
      r_half_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_lost        <= 1'b0;
    end else begin
      r_s1         <= clk_div_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_rise_pulse <= w_rise;
      r_fall_pulse <= w_fall;
      r_half_valid <= 1'b0;
      // locked trails the state by one cycle
      r_locked     <= (r_state == ST_LOCKED);

      if (w_edge) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_edge) begin
        r_lost <= 1'b0;
        if (!w_seen) begin
          // First edge only establishes the reference
          r_state <= ST_TRACK;
          r_match <= '0;
        end else begin
          r_half_period <= r_cnt;
          r_half_valid  <= 1'b1;
          case (r_state)
            ST_TRACK: begin
              if (w_in_tol) begin
                if (r_match == MATCH_W'(LOCK_COUNT - 1)) begin
                  r_state <= ST_LOCKED;
                  r_match <= '0;
                end else begin
                  r_match <= r_match + MATCH_W'(1);
                end
              end else begin
                r_match <= '0;
              end
            end
            ST_LOCKED: begin
              if (!w_in_tol) begin
                r_state <= ST_TRACK;
                r_match <= '0;
              end
            end
            default: begin
              r_state <= ST_TRACK;
              r_match <= '0;
            end
          endcase
        end
      end else if (w_timeout) begin
        r_state <= ST_IDLE;
        r_match <= '0;
        r_lost  <= 1'b1;
      end
    end
  end

  assign rise_pulse  = r_rise_pulse;
  assign fall_pulse  = r_fall_pulse;
  assign half_period = r_half_period;
  assign half_valid  = r_half_valid;
  assign locked      = r_locked;
  assign lost        = r_lost;

endmodule

// File: tb/tb_divided_clock_monitor.sv
// Bench for divided_clock_monitor: directed plus randomized half periods,
// compared every clk cycle against a timestamp-based reference model.
module tb_divided_clock_monitor;

  localparam int unsigned EXPECTED_HALF = 64;
  localparam int unsigned TOL           = 2;
  localparam int unsigned LOCK_COUNT    = 4;
  localparam int unsigned TIMEOUT       = 192;
  localparam int unsigned CNT_W         = 8;
  localparam int          CNT_MAX       = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clk_div_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] half_period;
  logic             half_valid;
  logic             locked;
  logic             lost;

  int checks = 0;
  int errors = 0;

  // Reference model state: sample history, edge timestamps, lock bookkeeping
  logic hist[$];
  int   n_cyc;
  int   last_edge;
  bit   m_seen;
  int   m_match;
  bit   m_lock_state;
  bit   e_rise, e_fall, e_hv, e_locked, e_lost;
  int   e_hp;

  divided_clock_monitor #(
    .EXPECTED_HALF(EXPECTED_HALF),
    .TOL          (TOL),
    .LOCK_COUNT   (LOCK_COUNT),
    .TIMEOUT      (TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div_in (clk_div_in),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .half_period(half_period),
    .half_valid (half_valid),
    .locked     (locked),
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, n_cyc, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("rise_pulse",  32'(rise_pulse),  32'(e_rise));
    chk("fall_pulse",  32'(fall_pulse),  32'(e_fall));
    chk("half_valid",  32'(half_valid),  32'(e_hv));
    chk("half_period", 32'(half_period), 32'(e_hp));
    chk("locked",      32'(locked),      32'(e_locked));
    chk("lost",        32'(lost),        32'(e_lost));
  endtask

  task automatic model_reset();
    hist.delete();
    n_cyc        = 0;
    last_edge    = 1;
    m_seen       = 1'b0;
    m_match      = 0;
    m_lock_state = 1'b0;
    e_rise = 1'b0; e_fall = 1'b0; e_hv = 1'b0; e_locked = 1'b0; e_lost = 1'b0;
    e_hp = 0;
  endtask

  // One clk cycle with clk_div_in held at v; model follows the behavioural rules
  task automatic step(input logic v);
    logic xa, xb;
    bit   edge_det, ok;
    int   age, d;
    clk_div_in = v;
    @(posedge clk);
    #1;
    hist.push_front(v);
    if (hist.size() > 8) void'(hist.pop_back());
    n_cyc++;
    // level seen by the edge detector is 2 samples old, its history 3
    xa = (hist.size() > 2) ? hist[2] : 1'b0;
    xb = (hist.size() > 3) ? hist[3] : 1'b0;
    edge_det = (xa != xb);
    age = n_cyc - last_edge;
    if (age > CNT_MAX) age = CNT_MAX;
    e_rise   = xa & ~xb;
    e_fall   = ~xa & xb;
    e_hv     = 1'b0;
    e_locked = m_lock_state;
    if (edge_det) begin
      e_lost = 1'b0;
      if (!m_seen) begin
        m_seen  = 1'b1;
        m_match = 0;
      end else begin
        e_hp = age;
        e_hv = 1'b1;
        d = age - int'(EXPECTED_HALF);
        if (d < 0) d = -d;
        ok = (d <= int'(TOL));
        if (m_lock_state) begin
          if (!ok) begin
            m_lock_state = 1'b0;
            m_match      = 0;
          end
        end else if (ok) begin
          m_match++;
          if (m_match == int'(LOCK_COUNT)) m_lock_state = 1'b1;
        end else begin
          m_match = 0;
        end
      end
      last_edge = n_cyc;
    end else if (age == int'(TIMEOUT)) begin
      m_seen       = 1'b0;
      m_match      = 0;
      m_lock_state = 1'b0;
      e_lost       = 1'b1;
    end
    check_all();
  endtask

  logic lvl;

  task automatic halves(input int len, input int count);
    for (int i = 0; i < count; i++) begin
      lvl = ~lvl;
      for (int c = 0; c < len; c++) step(lvl);
    end
  endtask

  task automatic do_reset(input logic din);
    clk_div_in = din;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    lvl = din;
  endtask

  initial begin
    rst_n      = 1'b0;
    clk_div_in = 1'b0;
    lvl        = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal 128-cycle period
    halves(64, 12);
    // Tolerance boundary: 66 locks, 67 never, 62 locks
    halves(66, 7);
    halves(67, 7);
    halves(62, 7);
    // Lock drop on a single 70-cycle half, then relock
    halves(64, 6);
    halves(70, 1);
    halves(64, 6);
    // Edge exactly on the timeout count is a measurement, not a loss
    halves(TIMEOUT, 1);
    halves(64, 6);
    // Randomized halves around nominal
    for (int i = 0; i < 24; i++) halves(int'($urandom_range(59, 69)), 1);
    halves(64, 6);
    // Clock loss while locked, then restart
    for (int c = 0; c < 260; c++) step(lvl);
    halves(64, 8);
    // Reset while locked, restart low
    do_reset(1'b0);
    halves(64, 7);
    // High at reset release
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) step(1'b1);
    halves(64, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
